glm_scale_update: RTL and testbench

Streaming vector update engine for the GLM pipeline, and the broadcast counterpart of the dot-product reduction stage. Per iteration it consumes one 32-bit scalar from the scalar results region (e.g. a dot-product or gradient value) and scales it by a step factor. It then streams `num_lines` cache lines of a feature vector `x` and a model vector `y`, and emits `y + coeff*x` line by line to the output write channel. It sits between the region-read FIFOs and the region writer, driven by the same `op_start`/`regs`/`op_done` instruction handshake as the other GLM compute stages.

---
 rtl/glm_pkg.sv | 41 ++++
 rtl/glm_axpy_lanes.sv | 89 ++++++++
 rtl/glm_scale_update.sv | 170 +++++++++++++++++
 tb/tb_glm_scale_update.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glm_pkg.sv
// -----------------------------------------------------------------------------
// glm_pkg
// Shared definitions for the GLM compute stages: cache-line width, the
// scale/update FSM state type, a lane-count helper and the signed fixed-point
// multiply-shift used by both the scalar path and the per-lane datapath.
// -----------------------------------------------------------------------------
package glm_pkg;

    localparam int CLDATA_WIDTH = 512;
    localparam int VALUE_WIDTH  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_SCALAR,
        S_WAIT_SCALAR,
        S_STREAM,
        S_DRAIN
    } t_scaleupdatestate;

    function automatic int lanes_per_line(input int log2_values_per_line);
        return 1 << log2_values_per_line;
    endfunction

    // Full 64-bit signed product, arithmetic shift right by frac_bits, keep the
    // low 32 bits (i.e. product bits [frac_bits+31:frac_bits]).
    function automatic logic [31:0] fx_mul_shift(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          frac_bits
    );
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [63:0] prod;
        sa   = a;
        sb   = b;
        prod = 64'(sa) * 64'(sb);
        prod = prod >>> frac_bits;
        return prod[31:0];
    endfunction

endpackage

// File: rtl/glm_axpy_lanes.sv
// -----------------------------------------------------------------------------
// glm_axpy_lanes
// Two-stage pipelined per-lane update out = y + ((coeff * x) >>> FRAC_BITS).
// Stage 1 registers the scaled x lanes together with y; stage 2 registers the
// wrapping 32-bit sum. Lines enter at one per cycle.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   coeff_i        scale factor, signed Q.FRAC_BITS, held stable while busy
//   x_line_i       feature line (lanes of 32-bit signed values)
//   y_line_i       model line
//   in_valid_i     x_line_i / y_line_i carry a line this cycle
//   out_valid_o    out_line_o carries a finished line this cycle
//   out_line_o     updated line
//   busy_o         a line is held in either pipeline stage
// -----------------------------------------------------------------------------
module glm_axpy_lanes
    import glm_pkg::*;
#(
    parameter int LOG2_VALUES_PER_LINE = 4,
    parameter int FRAC_BITS            = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             coeff_i,
    input  logic [CLDATA_WIDTH-1:0] x_line_i,
    input  logic [CLDATA_WIDTH-1:0] y_line_i,
    input  logic                    in_valid_i,
    output logic                    out_valid_o,
    output logic [CLDATA_WIDTH-1:0] out_line_o,
    output logic                    busy_o
);

    // LANES * VALUE_WIDTH is expected to equal CLDATA_WIDTH.
    localparam int LANES = lanes_per_line(LOG2_VALUES_PER_LINE);

    logic [1:0]              valid_q;
    logic [CLDATA_WIDTH-1:0] prod_d;
    logic [CLDATA_WIDTH-1:0] prod_q;
    logic [CLDATA_WIDTH-1:0] y_q;
    logic [CLDATA_WIDTH-1:0] sum_d;
    logic [CLDATA_WIDTH-1:0] sum_q;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_d[i*VALUE_WIDTH +: VALUE_WIDTH] =
                fx_mul_shift(coeff_i, x_line_i[i*VALUE_WIDTH +: VALUE_WIDTH], FRAC_BITS);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d[i*VALUE_WIDTH +: VALUE_WIDTH] =
                y_q[i*VALUE_WIDTH +: VALUE_WIDTH] + prod_q[i*VALUE_WIDTH +: VALUE_WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            sum_q   <= '0;
        end else begin
            valid_q <= {valid_q[0], in_valid_i};
            if (valid_q[0]) begin
                sum_q <= sum_d;
            end
        end
    end

    // NOTE: staging data is qualified by valid_q, so it carries no reset;
    // only the valid bits and the externally visible line are cleared.
    always_ff @(posedge clk) begin
        if (in_valid_i) begin
            prod_q <= prod_d;
            y_q    <= y_line_i;
        end
    end

    assign out_valid_o = valid_q[1];
    assign out_line_o  = sum_q;
    assign busy_o      = |valid_q;

endmodule

// File: rtl/glm_scale_update.sv
// -----------------------------------------------------------------------------
// glm_scale_update
// Streaming vector update engine: per iteration reads one scalar, scales it by
// step into coeff, then streams num_lines lines of x and y and writes
// y + coeff*x line by line.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   op_start / op_done          instruction handshake (op_done is a 1-cycle pulse)
//   regs[4]                     [0] = {num_iterations, num_lines}, [1] = step
//   scalar_* / x_* / y_*        FIFO read ports (empty, re, rvalid, rdata)
//   out_we, out_wdata           output line write channel
//   out_almostfull              output backpressure, gates read issue only
// -----------------------------------------------------------------------------
module glm_scale_update
    import glm_pkg::*;
#(
    parameter int LOG2_VALUES_PER_LINE = 4,
    parameter int FRAC_BITS            = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op_start,
    output logic                    op_done,
    input  logic [31:0]             regs [4],
    input  logic                    scalar_empty,
    output logic                    scalar_re,
    input  logic                    scalar_rvalid,
    input  logic [31:0]             scalar_rdata,
    input  logic                    x_empty,
    output logic                    x_re,
    input  logic                    x_rvalid,
    input  logic [CLDATA_WIDTH-1:0] x_rdata,
    input  logic                    y_empty,
    output logic                    y_re,
    input  logic                    y_rvalid,
    input  logic [CLDATA_WIDTH-1:0] y_rdata,
    output logic                    out_we,
    output logic [CLDATA_WIDTH-1:0] out_wdata,
    input  logic                    out_almostfull
);

    t_scaleupdatestate state_q, state_d;
    logic [15:0] num_lines_q, num_lines_d;
    logic [15:0] num_iters_q, num_iters_d;
    logic [15:0] iter_q, iter_d;
    logic [15:0] line_q, line_d;
    logic [31:0] step_q, step_d;
    logic [31:0] coeff_q, coeff_d;
    logic        op_done_q, op_done_d;
    logic        issue;
    logic        lanes_busy;

    // Reserved instruction words are intentionally ignored.
    logic unused_regs;
    assign unused_regs = ^{regs[2], regs[3]};

    always_comb begin
        state_d     = state_q;
        num_lines_d = num_lines_q;
        num_iters_d = num_iters_q;
        iter_d      = iter_q;
        line_d      = line_q;
        step_d      = step_q;
        coeff_d     = coeff_q;
        op_done_d   = 1'b0;
        scalar_re   = 1'b0;
        issue       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_start) begin
                    num_lines_d = regs[0][15:0];
                    num_iters_d = regs[0][31:16];
                    step_d      = regs[1];
                    iter_d      = '0;
                    line_d      = '0;
                    if (regs[0][31:16] == 16'd0) begin
                        op_done_d = 1'b1;
                    end else begin
                        state_d = S_LOAD_SCALAR;
                    end
                end
            end

            S_LOAD_SCALAR: begin
                if (!scalar_empty) begin
                    scalar_re = 1'b1;
                    state_d   = S_WAIT_SCALAR;
                end
            end

            S_WAIT_SCALAR: begin
                if (scalar_rvalid) begin
                    coeff_d = fx_mul_shift(scalar_rdata, step_q, FRAC_BITS);
                    line_d  = '0;
                    state_d = (num_lines_q == 16'd0) ? S_DRAIN : S_STREAM;
                end
            end

            S_STREAM: begin
                if (!x_empty && !y_empty && !out_almostfull) begin
                    issue  = 1'b1;
                    line_d = line_q + 16'd1;
                    if (line_d == num_lines_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // A read issued in the last STREAM cycle shows up as rvalid
                // here, before the lanes see it, so both must be quiet.
                if (!lanes_busy && !x_rvalid && !y_rvalid) begin
                    iter_d = iter_q + 16'd1;
                    if (iter_d == num_iters_q) begin
                        op_done_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_LOAD_SCALAR;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            num_lines_q <= '0;
            num_iters_q <= '0;
            iter_q      <= '0;
            line_q      <= '0;
            step_q      <= '0;
            coeff_q     <= '0;
            op_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_lines_q <= num_lines_d;
            num_iters_q <= num_iters_d;
            iter_q      <= iter_d;
            line_q      <= line_d;
            step_q      <= step_d;
            coeff_q     <= coeff_d;
            op_done_q   <= op_done_d;
        end
    end

    assign x_re    = issue;
    assign y_re    = issue;
    assign op_done = op_done_q;

    glm_axpy_lanes #(
        .LOG2_VALUES_PER_LINE(LOG2_VALUES_PER_LINE),
        .FRAC_BITS           (FRAC_BITS)
    ) u_lanes (
        .clk        (clk),
        .reset      (reset),
        .coeff_i    (coeff_q),
        .x_line_i   (x_rdata),
        .y_line_i   (y_rdata),
        .in_valid_i (x_rvalid & y_rvalid),
        .out_valid_o(out_we),
        .out_line_o (out_wdata),
        .busy_o     (lanes_busy)
    );

endmodule

// File: tb/tb_glm_scale_update.sv
// -----------------------------------------------------------------------------
// tb_glm_scale_update
// Directed bench for glm_scale_update: latency-1 FIFO models feed scalar, x and
// y; a negedge monitor counts handshakes and captures written lines; one task
// per scenario compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_glm_scale_update;

    localparam int W = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          op_start = 1'b0;
    logic          op_done;
    logic [31:0]   regs [4];
    logic          scalar_empty, scalar_re;
    logic          scalar_rvalid = 1'b0;
    logic [31:0]   scalar_rdata = '0;
    logic          x_empty, x_re;
    logic          x_rvalid = 1'b0;
    logic [W-1:0]  x_rdata = '0;
    logic          y_empty, y_re;
    logic          y_rvalid = 1'b0;
    logic [W-1:0]  y_rdata = '0;
    logic          out_we;
    logic [W-1:0]  out_wdata;
    logic          out_almostfull = 1'b0;

    always #5 clk = ~clk;

    glm_scale_update #(
        .LOG2_VALUES_PER_LINE(4),
        .FRAC_BITS           (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .op_start      (op_start),
        .op_done       (op_done),
        .regs          (regs),
        .scalar_empty  (scalar_empty),
        .scalar_re     (scalar_re),
        .scalar_rvalid (scalar_rvalid),
        .scalar_rdata  (scalar_rdata),
        .x_empty       (x_empty),
        .x_re          (x_re),
        .x_rvalid      (x_rvalid),
        .x_rdata       (x_rdata),
        .y_empty       (y_empty),
        .y_re          (y_re),
        .y_rvalid      (y_rvalid),
        .y_rdata       (y_rdata),
        .out_we        (out_we),
        .out_wdata     (out_wdata),
        .out_almostfull(out_almostfull)
    );

    // ---------------- FIFO models (read latency 1) ----------------
    logic [31:0]  s_mem [64];
    logic [W-1:0] x_mem [64];
    logic [W-1:0] y_mem [64];
    int s_wr = 0, s_rd = 0, x_wr = 0, x_rd = 0, y_wr = 0, y_rd = 0;
    logic fifo_clr = 1'b0;
    logic x_stall = 1'b0;
    logic y_stall = 1'b0;

    assign scalar_empty = (s_wr == s_rd);
    assign x_empty      = (x_wr == x_rd) || x_stall;
    assign y_empty      = (y_wr == y_rd) || y_stall;

    always @(posedge clk) begin
        if (fifo_clr) begin
            s_rd <= s_wr;
            x_rd <= x_wr;
            y_rd <= y_wr;
            scalar_rvalid <= 1'b0;
            x_rvalid <= 1'b0;
            y_rvalid <= 1'b0;
        end else begin
            scalar_rvalid <= scalar_re;
            x_rvalid      <= x_re;
            y_rvalid      <= y_re;
            if (scalar_re) begin
                scalar_rdata <= s_mem[s_rd[5:0]];
                s_rd <= s_rd + 1;
            end
            if (x_re) begin
                x_rdata <= x_mem[x_rd[5:0]];
                x_rd <= x_rd + 1;
            end
            if (y_re) begin
                y_rdata <= y_mem[y_rd[5:0]];
                y_rd <= y_rd + 1;
            end
        end
    end

    // ---------------- Monitor ----------------
    int cyc = 0, n_sre = 0, n_xre = 0, n_pair_err = 0, n_af_re = 0;
    int n_we = 0, n_done = 0, last_we_cyc = 0, done_cyc = 0;
    logic [W-1:0] cap [128];

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (scalar_re) n_sre++;
            if (x_re) n_xre++;
            if (x_re !== y_re) n_pair_err++;
            if (x_re && out_almostfull) n_af_re++;
            if (out_we) begin
                cap[n_we[6:0]] = out_wdata;
                n_we++;
                last_we_cyc = cyc;
            end
            if (op_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    // ---------------- Helpers (stimulus only) ----------------
    function automatic logic [W-1:0] splat(input logic [31:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] pat_x(input int j);
        logic [W-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'((j + 1) << 16) + 32'(i << 8);
        return r;
    endfunction

    function automatic logic [W-1:0] pat_y(input int j);
        logic [W-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(i << 20) + 32'(j);
        return r;
    endfunction

    // Integer coeff c: (c<<16)*x >>> 16 is exactly c*x, so out = y + c*x.
    function automatic logic [W-1:0] exp_int(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input int c);
        logic [W-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = y[i*32 +: 32] + x[i*32 +: 32] * 32'(c);
        return r;
    endfunction

    task automatic push_scalar(input logic [31:0] v);
        s_mem[s_wr[5:0]] = v;
        s_wr++;
    endtask

    task automatic push_line(input logic [W-1:0] x, input logic [W-1:0] y);
        x_mem[x_wr[5:0]] = x;
        y_mem[y_wr[5:0]] = y;
        x_wr++;
        y_wr++;
    endtask

    task automatic set_regs(input logic [15:0] lines, input logic [15:0] iters,
                            input logic [31:0] step);
        regs[0] = {iters, lines};
        regs[1] = step;
        regs[2] = 32'hDEAD_BEEF;
        regs[3] = 32'hFFFF_FFFF;
    endtask

    task automatic start_op();
        @(posedge clk); #1;
        op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        int n;
        n = 0;
        while (n_done < target && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (n_done >= target);
    endtask

    task automatic clear_fifos();
        @(posedge clk); #1;
        fifo_clr = 1'b1;
        @(posedge clk); #1;
        fifo_clr = 1'b0;
    endtask

    // ---------------- Scenarios ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({op_done, scalar_re, x_re, y_re, out_we} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {op_done, scalar_re, x_re, y_re, out_we});
        else pass_cnt++;
        total_cnt++;
        if (out_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", out_wdata);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int bw, bd;
        bit ok;
        bw = n_we; bd = n_done;
        push_scalar(32'h0002_0000);
        push_line(splat(32'h0001_0000), splat(32'h0003_0000));
        set_regs(16'd1, 16'd1, 32'h0001_0000);
        start_op();
        wait_done(bd + 1, ok);
        total_cnt++;
        if (!ok) $display("FAIL basic_done: got %0d pulses want %0d", n_done - bd, 1);
        else pass_cnt++;
        total_cnt++;
        if (n_we - bw != 1) $display("FAIL basic_we_count: got %0d want 1", n_we - bw);
        else pass_cnt++;
        total_cnt++;
        if (cap[bw[6:0]] !== splat(32'h0005_0000))
            $display("FAIL basic_line: got %h want %h", cap[bw[6:0]], splat(32'h0005_0000));
        else pass_cnt++;
        total_cnt++;
        if (done_cyc <= last_we_cyc)
            $display("FAIL basic_done_order: done cyc %0d want after we cyc %0d", done_cyc, last_we_cyc);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (n_done - bd != 1) $display("FAIL basic_single_pulse: got %0d want 1", n_done - bd);
        else pass_cnt++;
    endtask

    task automatic test_negative();
        int bw, bd;
        bit ok;
        bw = n_we; bd = n_done;
        push_scalar(32'hFFFF_0000);
        push_line(splat(32'h0002_0000), splat(32'h0001_0000));
        set_regs(16'd1, 16'd1, 32'h0001_0000);
        start_op();
        wait_done(bd + 1, ok);
        total_cnt++;
        if (!ok || n_we - bw != 1 || cap[bw[6:0]] !== splat(32'hFFFF_0000))
            $display("FAIL negative_line: got %h (writes %0d) want %h", cap[bw[6:0]], n_we - bw,
                     splat(32'hFFFF_0000));
        else pass_cnt++;
    endtask

    // coeff 1.5 (step 0.5 * 3.0): exercises floor truncation and 32-bit wrap.
    task automatic test_fractional();
        int bw, bd;
        bit ok;
        logic [W-1:0] x, y, e;
        bw = n_we; bd = n_done;
        for (int i = 0; i < 16; i++) begin
            x[i*32 +: 32] = (i % 2 == 0) ? 32'h0001_0001 : 32'hFFFE_FFFF;
            y[i*32 +: 32] = 32'h0;
            e[i*32 +: 32] = (i % 2 == 0) ? 32'h0001_8001 : 32'hFFFE_7FFE;
        end
        y[31:0] = 32'h7FFF_FFFF;
        e[31:0] = 32'h8001_8000;
        push_scalar(32'h0003_0000);
        push_line(x, y);
        set_regs(16'd1, 16'd1, 32'h0000_8000);
        start_op();
        wait_done(bd + 1, ok);
        total_cnt++;
        if (!ok || cap[bw[6:0]] !== e)
            $display("FAIL fractional_line: got %h want %h", cap[bw[6:0]], e);
        else pass_cnt++;
    endtask

    task automatic test_multi_iter();
        int bw, bd, bs, idx;
        bit ok;
        logic [W-1:0] e;
        bw = n_we; bd = n_done; bs = n_sre;
        push_scalar(32'h0001_0000);
        push_scalar(32'h0002_0000);
        push_scalar(32'h0003_0000);
        for (int j = 0; j < 12; j++) push_line(pat_x(j), pat_y(j));
        set_regs(16'd4, 16'd3, 32'h0001_0000);
        start_op();
        wait_done(bd + 1, ok);
        total_cnt++;
        if (!ok || n_we - bw != 12) $display("FAIL multi_count: got %0d writes want 12", n_we - bw);
        else pass_cnt++;
        total_cnt++;
        if (n_sre - bs != 3) $display("FAIL multi_scalar_reads: got %0d want 3", n_sre - bs);
        else pass_cnt++;
        for (int j = 0; j < 12; j++) begin
            idx = bw + j;
            e = exp_int(pat_x(j), pat_y(j), j / 4 + 1);
            total_cnt++;
            if (cap[idx[6:0]] !== e) $display("FAIL multi_line%0d: got %h want %h", j, cap[idx[6:0]], e);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int bw, bd, bx, w0, x0, af0, n, idx;
        bit ok;
        logic [W-1:0] e;
        bw = n_we; bd = n_done; bx = n_xre;
        push_scalar(32'h0001_0000);
        for (int j = 0; j < 8; j++) push_line(splat(32'((j + 1) << 16)), splat(32'(j)));
        set_regs(16'd8, 16'd1, 32'h0001_0000);
        start_op();
        n = 0;
        while (n_xre - bx < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        out_almostfull = 1'b1;
        w0 = n_we; x0 = n_xre; af0 = n_af_re;
        repeat (10) @(posedge clk);
        #1;
        total_cnt++;
        if (n_xre - x0 != 0 || n_af_re != af0)
            $display("FAIL bp_no_issue: got %0d reads while full want 0", n_xre - x0);
        else pass_cnt++;
        total_cnt++;
        if (n_we - w0 > 3) $display("FAIL bp_trailing: got %0d writes want <= 3", n_we - w0);
        else pass_cnt++;
        out_almostfull = 1'b0;
        wait_done(bd + 1, ok);
        total_cnt++;
        if (!ok || n_we - bw != 8) $display("FAIL bp_count: got %0d writes want 8", n_we - bw);
        else pass_cnt++;
        for (int j = 0; j < 8; j++) begin
            idx = bw + j;
            e = splat(32'((j + 1) << 16) + 32'(j));
            total_cnt++;
            if (cap[idx[6:0]] !== e) $display("FAIL bp_line%0d: got %h want %h", j, cap[idx[6:0]], e);
            else pass_cnt++;
        end
    endtask

    task automatic test_starvation();
        int bw, bd, bp, n, idx;
        logic [W-1:0] e;
        bw = n_we; bd = n_done; bp = n_pair_err;
        push_scalar(32'h0001_0000);
        push_scalar(32'h0002_0000);
        for (int j = 0; j < 12; j++) push_line(pat_x(j), pat_y(j));
        set_regs(16'd6, 16'd2, 32'h0001_0000);
        start_op();
        n = 0;
        while (n_done < bd + 1 && n < 1000) begin
            @(posedge clk); #1;
            x_stall = ($urandom_range(0, 2) == 0);
            y_stall = ($urandom_range(0, 2) == 0);
            n++;
        end
        x_stall = 1'b0;
        y_stall = 1'b0;
        total_cnt++;
        if (n_pair_err != bp) $display("FAIL starve_paired: got %0d unpaired reads want 0", n_pair_err - bp);
        else pass_cnt++;
        total_cnt++;
        if (n_done - bd != 1 || n_we - bw != 12)
            $display("FAIL starve_count: got %0d writes %0d done want 12 1", n_we - bw, n_done - bd);
        else pass_cnt++;
        for (int j = 0; j < 12; j++) begin
            idx = bw + j;
            e = exp_int(pat_x(j), pat_y(j), j / 6 + 1);
            total_cnt++;
            if (cap[idx[6:0]] !== e) $display("FAIL starve_line%0d: got %h want %h", j, cap[idx[6:0]], e);
            else pass_cnt++;
        end
    endtask

    task automatic test_zero_iterations();
        int bd, bs, bx;
        bd = n_done; bs = n_sre; bx = n_xre;
        set_regs(16'd5, 16'd0, 32'h0001_0000);
        @(posedge clk); #1;
        op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        total_cnt++;
        if (op_done !== 1'b1) $display("FAIL zero_iter_done: got %b want 1", op_done);
        else pass_cnt++;
        repeat (4) @(posedge clk);
        #1;
        total_cnt++;
        if (op_done !== 1'b0 || n_done - bd != 1)
            $display("FAIL zero_iter_pulse: got op_done=%b pulses=%0d want 0 1", op_done, n_done - bd);
        else pass_cnt++;
        total_cnt++;
        if (n_sre != bs || n_xre != bx)
            $display("FAIL zero_iter_reads: got %0d scalar %0d line reads want 0 0", n_sre - bs, n_xre - bx);
        else pass_cnt++;
    endtask

    task automatic test_zero_lines();
        int bd, bs, bx, bw;
        bit ok;
        bd = n_done; bs = n_sre; bx = n_xre; bw = n_we;
        push_scalar(32'h0001_0000);
        push_scalar(32'h0002_0000);
        set_regs(16'd0, 16'd2, 32'h0001_0000);
        start_op();
        wait_done(bd + 1, ok);
        total_cnt++;
        if (!ok) $display("FAIL zero_lines_done: got %0d pulses want 1", n_done - bd);
        else pass_cnt++;
        total_cnt++;
        if (n_sre - bs != 2) $display("FAIL zero_lines_scalars: got %0d want 2", n_sre - bs);
        else pass_cnt++;
        total_cnt++;
        if (n_we != bw || n_xre != bx)
            $display("FAIL zero_lines_writes: got %0d writes %0d reads want 0 0", n_we - bw, n_xre - bx);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_stream();
        int bx, bw, bd, n;
        bit ok;
        bx = n_xre;
        push_scalar(32'h0001_0000);
        for (int j = 0; j < 8; j++) push_line(splat(32'h0001_0000), splat(32'(j)));
        set_regs(16'd8, 16'd1, 32'h0001_0000);
        start_op();
        n = 0;
        while (n_xre - bx < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({op_done, scalar_re, x_re, y_re, out_we} !== 5'b0)
            $display("FAIL midreset_ctrl: got %b want 00000", {op_done, scalar_re, x_re, y_re, out_we});
        else pass_cnt++;
        total_cnt++;
        if (out_wdata !== '0) $display("FAIL midreset_wdata: got %h want 0", out_wdata);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_fifos();
        bw = n_we; bd = n_done;
        push_scalar(32'h0001_0000);
        push_line(splat(32'h0001_8000), splat(32'h0000_1000));
        set_regs(16'd1, 16'd1, 32'h0002_0000);
        start_op();
        wait_done(bd + 1, ok);
        total_cnt++;
        if (!ok || n_we - bw != 1 || cap[bw[6:0]] !== splat(32'h0003_1000))
            $display("FAIL after_reset_line: got %h (writes %0d) want %h", cap[bw[6:0]], n_we - bw,
                     splat(32'h0003_1000));
        else pass_cnt++;
    endtask

    initial begin
        set_regs(16'd0, 16'd0, 32'h0);
        test_reset();
        test_basic();
        test_negative();
        test_fractional();
        test_multi_iter();
        test_backpressure();
        test_starvation();
        test_zero_iterations();
        test_zero_lines();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", pass_cnt, total_cnt);
        $fatal(1, "time limit");
    end

endmodule
